// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//
// MiniUART receive engine. Recovers LSB-first asynchronous frames
// (start, DATA_BITS data, optional parity, stop) from the serial rxd line by
// sampling each bit in its middle. A 16x-oversample tick (en_rx) from the baud
// divisor paces the engine. Each received byte is handed to the bus-side
// register file through a valid/ack handshake, along with frame-error,
// parity-error and overrun status.
//
// Optional feature: define UART_RX_PARITY_EN to receive and check one parity
// bit between the data bits and the stop bit. Without it, frames have no
// parity bit and parity_err is tied to 0.
//
// Parameters
//   DATA_BITS    data bits per frame, 5..8
//   SYNC_STAGES  rxd synchronizer depth, >= 2
//   PARITY_ODD   1 = odd parity, 0 = even (used only with UART_RX_PARITY_EN)
//
// Ports
//   clk         UART clock
//   rst         asynchronous reset, active high
//   en_rx       one-clk tick at 16x the baud rate
//   rxd         serial input, idle high, asynchronous to clk
//   rd_ack      one-clk pulse, the bus has read rx_data
//   rx_data     received data, bits above DATA_BITS-1 read 0
//   rx_valid    rx_data holds an unread frame
//   frame_err   stop bit of the frame in rx_data was sampled 0
//   parity_err  parity mismatch of the frame in rx_data
//   overrun     sticky, a frame was loaded over an unread one
//   busy        receiver is inside a frame (state != IDLE)
// ---------------------------------------------------------------------------
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_rx,
  input  logic       rxd,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  // Catch illegal parameter combinations at elaboration time rather than
  // building a receiver that silently misframes.
  if (DATA_BITS < 5 || DATA_BITS > 8 || SYNC_STAGES < 2 ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
    $error("uart_rx_core: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic [3:0]             tick_cnt;
  logic [2:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   load_stb;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bit;
`endif

  // rxd is asynchronous to clk, so it passes a chain of flops before any
  // decision is made. The chain resets to 1 so that reset looks like an idle
  // line and cannot fake a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // The frame is complete on the tick that samples the middle of the stop
  // bit. Outputs update on that same edge, with no extra pipeline stage.
  assign load_stb = en_rx && (state == STOP) && (tick_cnt == 4'd15);

  assign busy = (state != IDLE);

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Receive state machine and the bus-facing status registers.
  // The FSM moves only on en_rx ticks. The start bit is qualified at its
  // midpoint (8 ticks in). After that, every bit is sampled 16 ticks later,
  // which again lands at the bit's midpoint. Data arrives LSB first and is
  // shifted in from the top, so the first bit ends up at bit 0.
  // For the handshake, a load always wins over a coincident rd_ack. Loading
  // while an unread frame is pending (and not being acked) sets overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      if (load_stb) begin
        rx_data   <= 8'(shreg);
        frame_err <= ~rxd_s;
        rx_valid  <= 1'b1;
        if (rx_valid && !rd_ack) begin
          overrun <= 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        parity_err <= (^shreg) ^ parity_bit ^ (PARITY_ODD != 0);
`endif
      end else if (rd_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      if (en_rx) begin
        case (state)
          IDLE: begin
            if (!rxd_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end

          START: begin
            if (tick_cnt == 4'd7) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (!rxd_s) begin
                state <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          DATA: begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == 3'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              parity_bit <= rxd_s;
              state      <= STOP;
            end
          end
`endif

          STOP: begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              state <= IDLE;
            end
          end

          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
//
// Self-checking bench for uart_rx_core. It drives serial frames with one bit
// lasting 64 clk (en_rx every 4 clk). For each frame it pushes the expected
// result into a scoreboard queue, then pops and compares that entry once the
// receiver presents the frame. Parity cases are built only when
// UART_RX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int BitClks    = 64;
  localparam bit ParityOdd  = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    logic       ovr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en_rx;
  logic       rxd;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  exp_t sb_q[$];
  logic model_valid;
  logic model_ovr;
  int   total;
  int   bad;
  logic [1:0] tick_div;

  uart_rx_core #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2),
    .PARITY_ODD (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_rx     (en_rx),
    .rxd       (rxd),
    .rd_ack    (rd_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 16x baud tick: one clk out of every four.
  initial begin
    en_rx    = 1'b0;
    tick_div = 2'd0;
    forever begin
      @(negedge clk);
      tick_div = tick_div + 2'd1;
      en_rx    = (tick_div == 2'd0);
    end
  end

  // Hard stop in case the bench hangs.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point. It counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic driveBit(input logic b);
    rxd = b;
    repeat (BitClks) @(negedge clk);
  endtask

  // Drive one full frame followed by one idle bit time. Record what the
  // receiver must present.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input logic par_bit);
    exp_t e;
    e.data = data;
    e.ferr = ~stop_bit;
`ifdef UART_RX_PARITY_EN
    e.perr = (^data) ^ par_bit ^ ParityOdd;
`else
    e.perr = 1'b0 & par_bit;
`endif
    e.ovr       = model_valid ? 1'b1 : model_ovr;
    model_valid = 1'b1;
    model_ovr   = e.ovr;
    sb_q.push_back(e);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
    driveBit(par_bit);
`endif
    driveBit(stop_bit);
    driveBit(1'b1);
  endtask

  // Wait (bounded) for the frame to appear. Then pop and compare.
  task automatic checkFrame(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (rx_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, rx_valid, 1);
    if (sb_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      checkOutput({tag, "_data"}, rx_data, e.data);
      checkOutput({tag, "_ferr"}, frame_err, e.ferr);
      checkOutput({tag, "_perr"}, parity_err, e.perr);
      checkOutput({tag, "_ovr"}, overrun, e.ovr);
      checkOutput({tag, "_busy"}, busy, 0);
    end
  endtask

  task automatic ackRead(input string tag);
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    model_valid = 1'b0;
    model_ovr   = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_ack_valid"}, rx_valid, model_valid);
    checkOutput({tag, "_ack_ovr"}, overrun, model_ovr);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    model_valid = 1'b0;
    model_ovr   = 1'b0;
    rst         = 1'b1;
    rxd         = 1'b1;
    rd_ack      = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    checkOutput("rst_data", rx_data, 0);
    checkOutput("rst_valid", rx_valid, 0);
    checkOutput("rst_ferr", frame_err, 0);
    checkOutput("rst_perr", parity_err, 0);
    checkOutput("rst_ovr", overrun, 0);
    checkOutput("rst_busy", busy, 0);
    repeat (BitClks) @(negedge clk);

    // Clean frame, then read it.
    applyStimulus(8'hA5, 1'b1, 1'b0);
    checkFrame("a5");
    ackRead("a5");

    // Broken stop bit.
    applyStimulus(8'h3C, 1'b0, 1'b0);
    checkFrame("3c_ferr");
    ackRead("3c_ferr");

    // Glitch on the line: about 5 ticks low, then high again.
    @(negedge clk);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    checkOutput("glitch_busy_hi", busy, 1);
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (BitClks) @(negedge clk);
    checkOutput("glitch_busy_lo", busy, 0);
    checkOutput("glitch_valid", rx_valid, 0);

    // Two frames without a read in between.
    applyStimulus(8'h11, 1'b1, 1'b0);
    checkFrame("11");
    applyStimulus(8'h22, 1'b1, 1'b0);
    checkFrame("22_ovr");
    ackRead("22_ovr");

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs a 1 in the parity bit.
    applyStimulus(8'h07, 1'b1, 1'b0);
    checkFrame("par_bad");
    ackRead("par_bad");
    applyStimulus(8'h07, 1'b1, 1'b1);
    checkFrame("par_good");
    ackRead("par_good");
`endif

    // Leave a frame unread, then reset in the middle of the next frame.
    applyStimulus(8'h5A, 1'b1, 1'b0);
    checkFrame("5a");
    driveBit(1'b0);
    for (int i = 0; i < 3; i++) driveBit(1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_data", rx_data, 0);
    checkOutput("mid_rst_valid", rx_valid, 0);
    checkOutput("mid_rst_ferr", frame_err, 0);
    checkOutput("mid_rst_perr", parity_err, 0);
    checkOutput("mid_rst_ovr", overrun, 0);
    checkOutput("mid_rst_busy", busy, 0);
    sb_q.delete();
    model_valid = 1'b0;
    model_ovr   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (BitClks) @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);

    // 0x3C has an even number of ones, so the even parity bit is 0.
    applyStimulus(8'h3C, 1'b1, 1'b0);
    checkFrame("3c_after_rst");

    checkOutput("sb_drain", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
